// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

   localparam int unsigned DEPTH_WORDS_DEF = 256;
   localparam int unsigned WAIT_CYCLES_DEF = 2;
   localparam int unsigned CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   // Word-index width, kept at least one bit for single-word memories.
   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with one write port and one registered, write-first read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int unsigned AW          = addr_w(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic          rclr,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_d, rdata_q;

   // Contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // A read coinciding with a write to the same word returns the new data.
   always_comb begin
      rdata_d = rdata_q;
      if (rclr) begin
         rdata_d = '0;
      end else if (re) begin
         rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: captures a core request, inserts
// WAIT_CYCLES wait states, then strobes ready_out with data and error status.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        readCntrl_in,
   input  logic        writeCntrl_in,
   input  logic [31:0] address_in,
   input  logic [31:0] writeData_in,
   output logic [31:0] data_out,
   output logic        ready_out,
   output logic        error_out
);

   localparam int unsigned AW = addr_w(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   state_t           state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             rd_d, rd_q, wr_d, wr_q;
   logic [31:0]      addr_d, addr_q, wdata_d, wdata_q;
   logic             ready_d, ready_q, error_d, error_q;

   logic             cur_rd, cur_wr, req_valid, commit;
   logic [31:0]      cur_addr, cur_wdata;
   logic             mem_we, mem_re, mem_clr;

   // With no wait states the commit edge is the capture edge, so use live inputs.
   always_comb begin
      if (state_q == IDLE) begin
         cur_rd    = readCntrl_in;
         cur_wr    = writeCntrl_in;
         cur_addr  = address_in;
         cur_wdata = writeData_in;
      end else begin
         cur_rd    = rd_q;
         cur_wr    = wr_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
      end
   end

   assign req_valid = (cur_addr[1:0] == 2'b00)
                   && (32'(cur_addr[31:2]) < 32'(DEPTH_WORDS))
                   && !(cur_rd && cur_wr);

   // Next-state, capture and response-strobe logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ready_d = 1'b0;
      error_d = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (readCntrl_in || writeCntrl_in) begin
               rd_d    = readCntrl_in;
               wr_d    = writeCntrl_in;
               addr_d  = address_in;
               wdata_d = writeData_in;
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = RESPOND;
                  commit  = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESPOND;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (commit) begin
         ready_d = 1'b1;
         error_d = !req_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
      end
   end

   // Reset must suppress the commit of an in-flight transaction.
   assign mem_we  = commit && req_valid && cur_wr && !reset;
   assign mem_re  = commit && req_valid && cur_rd;
   assign mem_clr = reset || (commit && !req_valid);

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .waddr (cur_addr[AW+1:2]),
      .wdata (cur_wdata),
      .re    (mem_re),
      .rclr  (mem_clr),
      .raddr (cur_addr[AW+1:2]),
      .rdata (data_out)
   );

   assign ready_out = ready_q;
   assign error_out = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0).
module tb_dmem_responder;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_in, wr_in;
   logic [31:0] addr_in, wd_in;
   logic [31:0] dout;
   logic        ready, err;

   logic        rd0, wr0;
   logic [31:0] a0, d0;
   logic [31:0] dout0;
   logic        ready0, err0;

   int          vectors    = 0;
   int          miscompares = 0;
   exp_t        sb_q[$];
   logic [31:0] model_mem [256];
   logic [31:0] last_dout = 32'h0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .readCntrl_in(rd_in), .writeCntrl_in(wr_in),
      .address_in(addr_in), .writeData_in(wd_in), .data_out(dout),
      .ready_out(ready), .error_out(err)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .readCntrl_in(rd0), .writeCntrl_in(wr0),
      .address_in(a0), .writeData_in(d0), .data_out(dout0),
      .ready_out(ready0), .error_out(err0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request to the WAIT_CYCLES=2 DUT, model it, then score its response.
   task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      logic valid;
      exp_t ex;
      exp_t got;
      int   n;
      @(negedge clk);
      rd_in = rd; wr_in = wr; addr_in = a; wd_in = d;
      valid = (a[1:0] == 2'b00) && (a < 32'h400) && !(rd && wr);
      if (valid && wr) model_mem[a[9:2]] = d;
      ex.d = !valid ? 32'h0 : (rd ? model_mem[a[9:2]] : last_dout);
      ex.e = !valid;
      last_dout = ex.d;
      sb_q.push_back(ex);
      @(posedge clk); #1;
      rd_in = 1'b0; wr_in = 1'b0;
      check("ready_early", 32'(ready), 32'h0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready && n < 20);
      check("latency", 32'(n), 32'd2);
      got = sb_q.pop_front();
      check("data_out", dout, got.d);
      check("error_out", 32'(err), 32'(got.e));
      @(posedge clk); #1;
      check("ready_one_cycle", 32'(ready), 32'h0);
      check("error_idle", 32'(err), 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      rd_in = 1'b0; wr_in = 1'b0; addr_in = '0; wd_in = '0;
      rd0 = 1'b0; wr0 = 1'b0; a0 = '0; d0 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_error", 32'(err), 32'h0);
      check("rst_data", dout, 32'h0);
      check("rst_ready0", 32'(ready0), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      req(1'b1, 1'b0, 32'h10, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      check("data_hold", dout, 32'hDEADBEEF);

      req(1'b0, 1'b1, 32'h12, 32'h12345678);
      req(1'b1, 1'b0, 32'h10, 32'h0);
      req(1'b1, 1'b0, 32'h400, 32'h0);
      req(1'b1, 1'b0, 32'h10, 32'h0);
      req(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF);
      req(1'b1, 1'b0, 32'h10, 32'h0);
      req(1'b0, 1'b1, 32'h3FC, 32'h0BADF00D);
      req(1'b1, 1'b0, 32'h3FC, 32'h0);

      // Reset in the first wait cycle of a write must abort it.
      req(1'b0, 1'b1, 32'h20, 32'h11111111);
      @(negedge clk);
      wr_in = 1'b1; addr_in = 32'h20; wd_in = 32'hA5A5A5A5;
      @(posedge clk); #1;
      wr_in = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_ready", 32'(ready), 32'h0);
      check("abort_error", 32'(err), 32'h0);
      check("abort_data", dout, 32'h0);
      last_dout = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("abort_no_strobe", 32'(ready), 32'h0);
      end
      req(1'b1, 1'b0, 32'h20, 32'h0);

      // Reset wins over a request presented in the same cycle.
      @(negedge clk);
      reset = 1'b1; rd_in = 1'b1; addr_in = 32'h10;
      @(posedge clk); #1;
      reset = 1'b0; rd_in = 1'b0;
      last_dout = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("rst_prio_no_strobe", 32'(ready), 32'h0);
      end
      check("rst_prio_data", dout, 32'h0);

      // Zero wait states with the request held: strobe every other cycle.
      @(negedge clk);
      wr0 = 1'b1; a0 = 32'h40; d0 = 32'hCAFEF00D;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("w0_ready", 32'(ready0), 32'((i % 2) == 0));
         check("w0_error", 32'(err0), 32'h0);
      end
      @(negedge clk);
      wr0 = 1'b0; rd0 = 1'b1;
      @(posedge clk); #1;
      rd0 = 1'b0;
      check("w0_rd_ready", 32'(ready0), 32'h1);
      check("w0_rd_data", dout0, 32'hCAFEF00D);
      check("w0_rd_error", 32'(err0), 32'h0);
      @(posedge clk); #1;
      check("w0_rd_ready_off", 32'(ready0), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
